// File: rtl/lbm_cell_loader.sv
// Population loader: fetches nine Q3.13 words per cell from a 1-cycle-latency memory and presents
// them to the collider under valid/ready. Optional next-cell shadow prefetch: LBM_LOADER_PREFETCH_EN.
module lbm_cell_loader #(
  parameter int unsigned NUM_CELLS = 64,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0,
  localparam int unsigned CellW    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [15:0]       i_mem_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CellW-1:0]  o_cell_idx,
  output logic [15:0]       o_f_null,
  output logic [15:0]       o_f_n,
  output logic [15:0]       o_f_ne,
  output logic [15:0]       o_f_e,
  output logic [15:0]       o_f_se,
  output logic [15:0]       o_f_s,
  output logic [15:0]       o_f_sw,
  output logic [15:0]       o_f_w,
  output logic [15:0]       o_f_nw
);

  localparam logic [CellW-1:0]  LastCell = CellW'(NUM_CELLS - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [3:0]        LastDir  = 4'd8;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StPresent} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_dir, w_dir_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [CellW-1:0]  r_cell, w_cell_d;
  logic              r_done, w_done_d;
  logic              w_mem_en;
  logic              r_cap_vld;
  logic [3:0]        r_cap_dir;
  logic [15:0]       r_f [9];
  logic [15:0]       w_f_d [9];
  logic              w_valid, w_hs, w_last_cell;

  assign w_hs        = w_valid & i_out_ready;
  assign w_last_cell = (r_cell == LastCell);

`ifdef LBM_LOADER_PREFETCH_EN
  logic              r_valid, w_valid_d;
  logic [15:0]       r_shadow [9];
  logic [15:0]       w_shadow_d [9];
  logic              r_shadow_full, w_shadow_full_d;
  logic [CellW-1:0]  r_fetch_cell, w_fetch_cell_d;
  logic              w_cap_last, w_f_free, w_can_start, w_more;

  assign w_valid    = r_valid;
  assign w_cap_last = r_cap_vld & (r_cap_dir == LastDir);
  assign w_f_free   = ~r_valid | w_hs;
  assign w_more     = (r_fetch_cell != LastCell);
  // A new fill may only start once the shadow bank cannot still be holding an unconsumed cell.
  assign w_can_start = ~r_shadow_full & (~w_cap_last | w_f_free);

  always_comb begin
    w_state_d      = r_state;
    w_dir_d        = r_dir;
    w_addr_d       = r_addr;
    w_cell_d       = r_cell;
    w_fetch_cell_d = r_fetch_cell;
    w_done_d       = 1'b0;
    w_mem_en       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d      = StFetch;
          w_dir_d        = 4'd0;
          w_addr_d       = BaseAddr;
          w_cell_d       = '0;
          w_fetch_cell_d = '0;
        end
      end
      StFetch: begin
        w_mem_en = 1'b1;
        w_addr_d = r_addr + 1'b1;
        if (r_dir == LastDir) begin
          w_dir_d   = 4'd0;
          w_state_d = StDrain;
        end else begin
          w_dir_d = r_dir + 4'd1;
        end
      end
      StDrain, StPresent: begin
        // Issue dir 0 of the next cell straight away so fills run back to back.
        if (w_more && w_can_start) begin
          w_mem_en       = 1'b1;
          w_addr_d       = r_addr + 1'b1;
          w_dir_d        = 4'd1;
          w_fetch_cell_d = r_fetch_cell + 1'b1;
          w_state_d      = StFetch;
        end else begin
          w_state_d = StPresent;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_hs) begin
      if (w_last_cell) begin
        w_done_d  = 1'b1;
        w_state_d = StIdle;
        w_cell_d  = '0;
      end else begin
        w_cell_d = r_cell + 1'b1;
      end
    end
  end

  always_comb begin
    w_valid_d       = r_valid;
    w_shadow_full_d = r_shadow_full;
    for (int i = 0; i < 9; i++) begin
      w_f_d[i]      = r_f[i];
      w_shadow_d[i] = r_shadow[i];
    end
    if (w_hs && r_shadow_full) begin
      for (int i = 0; i < 9; i++) w_f_d[i] = r_shadow[i];
      w_shadow_full_d = 1'b0;
    end else if (w_hs) begin
      w_valid_d = 1'b0;
    end
    if (r_cap_vld) begin
      if (w_cap_last && w_f_free) begin
        // Completing fill bypasses the shadow so the presented bank loads on the final capture.
        for (int i = 0; i < 8; i++) w_f_d[i] = r_shadow[i];
        w_f_d[8]  = i_mem_rdata;
        w_valid_d = 1'b1;
      end else begin
        for (int i = 0; i < 9; i++) begin
          if (r_cap_dir == 4'(i)) w_shadow_d[i] = i_mem_rdata;
        end
        if (w_cap_last) w_shadow_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid       <= 1'b0;
      r_shadow_full <= 1'b0;
      r_fetch_cell  <= '0;
      for (int i = 0; i < 9; i++) r_shadow[i] <= '0;
    end else begin
      r_valid       <= w_valid_d;
      r_shadow_full <= w_shadow_full_d;
      r_fetch_cell  <= w_fetch_cell_d;
      for (int i = 0; i < 9; i++) r_shadow[i] <= w_shadow_d[i];
    end
  end
`else
  assign w_valid = (r_state == StPresent);

  always_comb begin
    w_state_d = r_state;
    w_dir_d   = r_dir;
    w_addr_d  = r_addr;
    w_cell_d  = r_cell;
    w_done_d  = 1'b0;
    w_mem_en  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StFetch;
          w_dir_d   = 4'd0;
          w_addr_d  = BaseAddr;
          w_cell_d  = '0;
        end
      end
      StFetch: begin
        w_mem_en = 1'b1;
        w_addr_d = r_addr + 1'b1;
        if (r_dir == LastDir) begin
          w_dir_d   = 4'd0;
          w_state_d = StDrain;
        end else begin
          w_dir_d = r_dir + 4'd1;
        end
      end
      StDrain: w_state_d = StPresent;
      StPresent: begin
        if (w_hs) begin
          if (w_last_cell) begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
            w_cell_d  = '0;
          end else begin
            // Address register already points at the next cell's dir 0.
            w_cell_d  = r_cell + 1'b1;
            w_state_d = StFetch;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_f_d[i] = r_f[i];
      if (r_cap_vld && (r_cap_dir == 4'(i))) w_f_d[i] = i_mem_rdata;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_dir     <= 4'd0;
      r_addr    <= '0;
      r_cell    <= '0;
      r_done    <= 1'b0;
      r_cap_vld <= 1'b0;
      r_cap_dir <= 4'd0;
      for (int i = 0; i < 9; i++) r_f[i] <= '0;
    end else begin
      r_state   <= w_state_d;
      r_dir     <= w_dir_d;
      r_addr    <= w_addr_d;
      r_cell    <= w_cell_d;
      r_done    <= w_done_d;
      r_cap_vld <= w_mem_en;
      r_cap_dir <= r_dir;
      for (int i = 0; i < 9; i++) r_f[i] <= w_f_d[i];
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_mem_en    = w_mem_en;
  assign o_mem_addr  = r_addr;
  assign o_out_valid = w_valid;
  assign o_cell_idx  = r_cell;
  assign o_f_null    = r_f[0];
  assign o_f_n       = r_f[1];
  assign o_f_ne      = r_f[2];
  assign o_f_e       = r_f[3];
  assign o_f_se      = r_f[4];
  assign o_f_s       = r_f[5];
  assign o_f_sw      = r_f[6];
  assign o_f_w       = r_f[7];
  assign o_f_nw      = r_f[8];

endmodule

// File: doc/lbm_cell_loader.md
Name: lbm_cell_loader

Overview:
- Upstream feeder for the combinational collider.
- Fetches the nine Q3.13 populations of each lattice cell, in raster order, from a single-port population memory with one-cycle read latency, one word per cycle.
- Assembles the nine words into parallel registers and presents them to the collider under a valid/ready handshake.
- Sequences NUM_CELLS cells per start command and pulses done at the end.

Parameters:
- NUM_CELLS, 64, number of cells per sweep (>=1).
- ADDR_W, 12, population memory address width; must satisfy 9*NUM_CELLS <= 2**ADDR_W.
- BASE_ADDR, 0, address of cell 0, direction 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle sweep request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last cell's handshake.
- mem_en  out  1  read enable.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  16  read data, valid the cycle after mem_en.
- out_valid  out  1  population bundle valid.
- out_ready  in  1  consumer accepts the bundle.
- cell_idx  out  clog2(NUM_CELLS)  index of the presented cell.
- f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw  out  16 each  signed Q3.13 populations of the presented cell.

Behaviour:
- Reset: all outputs 0; state IDLE; cell counter 0; direction counter 0; f_* registers 0.
- Memory layout: address = BASE_ADDR + 9*cell + dir.
  - dir order: 0 null, 1 n, 2 ne, 3 e, 4 se, 5 s, 6 sw, 7 w, 8 nw.
  - Address computed with an incrementing register, not a multiplier.
- States: IDLE, FETCH, DRAIN, PRESENT.
- IDLE:
  - start=1 -> FETCH with cell=0, dir=0.
  - start while not IDLE is ignored.
- FETCH:
  - mem_en=1 each cycle, mem_addr for the current dir; dir increments.
  - After issuing dir 8 -> DRAIN.
- Capture: mem_rdata is registered into f_<dir> one cycle after that dir's address was issued. A one-cycle-delayed dir tag selects the destination register.
- DRAIN:
  - mem_en=0.
  - Captures the dir-8 word, then -> PRESENT.
  - out_valid rises on the cycle after the final capture edge.
- Latency: first address issued the cycle after start; out_valid asserted 10 cycles after the first address.
- PRESENT:
  - out_valid=1; f_* and cell_idx held stable.
  - out_valid is never dropped without a handshake.
  - On out_valid & out_ready:
    - If cell == NUM_CELLS-1: done=1 for one cycle, out_valid=0, -> IDLE.
    - Else: cell+1, dir=0, -> FETCH, out_valid=0.
- Throughput without the optional feature: 11 cycles per cell when out_ready is tied high.
- out_ready is ignored while out_valid=0.
- rst asserted mid-sweep:
  - Aborts immediately; next cycle all outputs at reset values.
  - No done pulse; the sweep is not resumed.
- NUM_CELLS=1: a single cell, with done following its handshake.
- mem_rdata is ignored in every cycle not following a mem_en cycle.

Optional Feature:
- Macro: LBM_LOADER_PREFETCH_EN.
- Defined:
  - Adds a shadow bank of nine 16-bit registers plus a shadow_full flag.
  - While PRESENT and a next cell exists, the loader fetches the next cell into the shadow bank (same FETCH/DRAIN timing) without disturbing f_*.
  - On handshake with shadow_full=1: shadow copies into f_*, cell_idx increments, out_valid stays 1 (no bubble), and the next prefetch begins the following cycle.
  - On handshake with the shadow partially filled: out_valid drops, fetching continues, and out_valid reasserts once the fill completes.
  - Steady-state throughput with out_ready high: one cell per 9 cycles.
- Undefined: shadow logic is absent and behaviour is exactly as above.

Test Plan:
- Memory preloaded with word[a]=a; start with NUM_CELLS=2, out_ready=1:
  - Cell 0 presents f_null=0x0000 through f_nw=0x0008, 11 cycles after start.
  - Cell 1 presents f_null=0x0009 through f_nw=0x0011.
  - done pulses exactly once.
- Rest cell, f_null=0x0E39, sides=0x038E, diagonals=0x00E4:
  - All nine registers match.
  - Collider rho output = 0x2000 ±2 LSB.
- out_ready held low for 20 cycles in PRESENT:
  - out_valid, f_*, and cell_idx stay stable.
  - mem_en=0 (feature off).
  - The handshake then advances to the next cell.
- start pulsed in FETCH: ignored; the cell count stays NUM_CELLS and a single done pulse occurs.
- rst asserted during FETCH of cell 1 at dir 4: all outputs 0 next cycle, no done, and a fresh start refetches from cell 0.
- With LBM_LOADER_PREFETCH_EN, NUM_CELLS=4, out_ready=1: out_valid handshakes are spaced 9 cycles apart after the first, with data correct for each cell.
